// File: rtl/mux_scan_sequencer.sv
// Round-robin scan controller for a WIDTH-bit NUM_CH-to-1 mux: drives sel, waits DWELL
// settle cycles, captures mux_out and offers it downstream over a valid/ready handshake.
module mux_scan_sequencer #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned DWELL  = 1,
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic [SEL_W-1:0]  sel_o,
  input  logic [WIDTH-1:0]  mux_out_i,
  output logic [WIDTH-1:0]  sample_data_o,
  output logic [SEL_W-1:0]  sample_ch_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] first_at_ptr;
  logic [SEL_W-1:0] first_after_sel;
  logic             mask_any;
  logic             dwell_done;

  // First set bit of mask at or after start, wrapping; returns start if mask is empty.
  function automatic logic [SEL_W-1:0] pick_first(input logic [NUM_CH-1:0] mask,
                                                  input logic [SEL_W-1:0]  start);
    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [SEL_W:0]      sum;
    logic [SEL_W-1:0]    res;
    res = start;
    sum = '0;
    dbl = {mask, mask};
    rot = NUM_CH'(dbl >> start);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = (SEL_W+1)'(start) + (SEL_W+1)'(i);
        res = (sum >= (SEL_W+1)'(NUM_CH)) ? SEL_W'(sum - (SEL_W+1)'(NUM_CH)) : SEL_W'(sum);
      end
    end
    return res;
  endfunction

  assign sel_inc         = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
  assign mask_any        = |ch_mask_i;
  assign first_at_ptr    = pick_first(ch_mask_i, ptr_q);
  assign first_after_sel = pick_first(ch_mask_i, sel_inc);
  assign dwell_done      = (cnt_q == CNT_W'(DWELL - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en_i && mask_any) begin
          sel_d   = first_at_ptr;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (dwell_done) begin
          data_d  = mux_out_i;
          ch_d    = sel_q;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        // The offered sample is never withdrawn; only the handshake leaves HOLD.
        if (sample_ready_i) begin
          valid_d = 1'b0;
          if (en_i && mask_any) begin
            sel_d   = first_after_sel;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            ptr_d   = first_after_sel;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign sel_o          = sel_q;
  assign sample_data_o  = data_q;
  assign sample_ch_o    = ch_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: scoreboard of expected (channel, data, cycle)
// samples compared against the sample handshake, plus reset, backpressure and enable scenarios.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [5:0] mask;
  logic [2:0] sel;
  logic [2:0] mux_out;
  logic [2:0] sdata;
  logic [2:0] sch;
  logic       svalid;
  logic       ready;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int exp_ch_q[$];
  int exp_data_q[$];
  int exp_cyc_q[$];

  mux_scan_sequencer #(.WIDTH(3), .NUM_CH(6), .DWELL(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en),
    .ch_mask_i      (mask),
    .sel_o          (sel),
    .mux_out_i      (mux_out),
    .sample_data_o  (sdata),
    .sample_ch_o    (sch),
    .sample_valid_o (svalid),
    .sample_ready_i (ready),
    .busy_o         (busy)
  );

  // Mux model: inputs A..F carry 1..6
  always_comb begin
    case (sel)
      3'd0: mux_out = 3'd1;
      3'd1: mux_out = 3'd2;
      3'd2: mux_out = 3'd3;
      3'd3: mux_out = 3'd4;
      3'd4: mux_out = 3'd5;
      3'd5: mux_out = 3'd6;
      default: mux_out = 3'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next(input logic [5:0] m, input int start);
    for (int j = 0; j < 6; j++) begin
      if (m[(start + j) % 6]) return (start + j) % 6;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; mask = 6'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    do_reset();
    mask = 6'h3F; en = 1'b1; ready = 1'b0;
    cyc = 0;
    while (!svalid && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if (!svalid) begin
      failures++;
      $display("FAIL reset_prep_timeout valid=%b required=1", svalid);
    end
    rst = 1'b1;
    tick();
    checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (svalid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", svalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sdata !== 3'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", sdata); end
    checks++; if (sch !== 3'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", sch); end
    tick();
    rst = 1'b0; en = 1'b0;
  endtask

  // Scan with ready tied high; expected samples pushed up front, popped on each handshake.
  task automatic run_scan(input logic [5:0] m, input int n, input string tag);
    int cyc, got, ch, ec, ed, ecy;
    do_reset();
    ch = model_next(m, 0);
    for (int k = 0; k < n; k++) begin
      exp_ch_q.push_back(ch);
      exp_data_q.push_back(ch + 1);
      exp_cyc_q.push_back(2 + 2 * k);
      ch = model_next(m, (ch + 1) % 6);
    end
    mask = m; ready = 1'b1; en = 1'b1;
    cyc = 0; got = 0;
    while (got < n && cyc < 4 * n + 10) begin
      tick();
      cyc++;
      if (busy) begin
        checks++;
        if (sel > 3'd5 || m[sel] !== 1'b1) begin
          failures++;
          $display("FAIL %s_sel_masked cycle=%0d sel=%0d mask=%b", tag, cyc, sel, m);
        end
      end
      if (svalid) begin
        ec = exp_ch_q.pop_front(); ed = exp_data_q.pop_front(); ecy = exp_cyc_q.pop_front();
        checks++;
        if (sch !== 3'(ec) || sdata !== 3'(ed) || cyc != ecy) begin
          failures++;
          $display("FAIL %s_sample%0d got ch=%0d data=%0d cycle=%0d exp ch=%0d data=%0d cycle=%0d",
                   tag, got, sch, sdata, cyc, ec, ed, ecy);
        end
        got++;
        if (got == n) en = 1'b0;
      end
    end
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL %s_timeout samples=%0d required=%0d", tag, got, n);
    end
    exp_ch_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
    tick();
    checks++;
    if (busy !== 1'b0 || svalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_after busy=%b valid=%b required 0/0", tag, busy, svalid);
    end
  endtask

  task automatic test_full_scan();
    run_scan(6'b111111, 7, "full");
  endtask

  task automatic test_masked_scan();
    run_scan(6'b100100, 4, "mask25");
    run_scan(6'b000001, 3, "mask0");
  endtask

  task automatic test_backpressure();
    int cyc, ec, ed;
    do_reset();
    exp_ch_q.push_back(0); exp_data_q.push_back(1);
    exp_ch_q.push_back(1); exp_data_q.push_back(2);
    mask = 6'h3F; en = 1'b1; ready = 1'b0;
    cyc = 0;
    while (!svalid && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 2) begin failures++; $display("FAIL bp_first_valid cycle=%0d required=2", cyc); end
    ec = exp_ch_q.pop_front(); ed = exp_data_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (svalid !== 1'b1 || sch !== 3'(ec) || sdata !== 3'(ed) || sel !== 3'(ec)) begin
        failures++;
        $display("FAIL bp_hold%0d valid=%b ch=%0d data=%0d sel=%0d exp 1/%0d/%0d/%0d",
                 i, svalid, sch, sdata, sel, ec, ed, ec);
      end
    end
    ready = 1'b1;
    tick();
    checks++;
    if (svalid !== 1'b0) begin failures++; $display("FAIL bp_accept valid=%b required=0", svalid); end
    tick();
    ec = exp_ch_q.pop_front(); ed = exp_data_q.pop_front();
    checks++;
    if (svalid !== 1'b1 || sch !== 3'(ec) || sdata !== 3'(ed)) begin
      failures++;
      $display("FAIL bp_next valid=%b ch=%0d data=%0d exp 1/%0d/%0d", svalid, sch, sdata, ec, ed);
    end
    en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle busy=%b required=0", busy); end
  endtask

  task automatic test_enable();
    int cyc;
    do_reset();
    mask = 6'h3F; ready = 1'b1; en = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || sel !== 3'd0) begin
      failures++;
      $display("FAIL en_settle busy=%b sel=%0d required 1/0", busy, sel);
    end
    en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || svalid !== 1'b0) begin
      failures++;
      $display("FAIL en_abort busy=%b valid=%b required 0/0", busy, svalid);
    end
    tick();
    checks++;
    if (svalid !== 1'b0) begin failures++; $display("FAIL en_abort_novalid valid=%b required=0", svalid); end
    ready = 1'b0; en = 1'b1;
    cyc = 0;
    while (!svalid && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if (svalid !== 1'b1 || sch !== 3'd0 || sdata !== 3'd1) begin
      failures++;
      $display("FAIL en_restart valid=%b ch=%0d data=%0d required 1/0/1", svalid, sch, sdata);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (svalid !== 1'b1 || sch !== 3'd0 || sdata !== 3'd1) begin
        failures++;
        $display("FAIL en_hold%0d valid=%b ch=%0d data=%0d required 1/0/1", i, svalid, sch, sdata);
      end
    end
    ready = 1'b1;
    tick();
    checks++;
    if (svalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL en_hold_release valid=%b busy=%b required 0/0", svalid, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL en_stay_idle busy=%b required=0", busy); end
    en = 1'b1;
    tick();
    checks++;
    if (sel !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL en_resume_ptr sel=%0d busy=%b required 1/1", sel, busy);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_empty_mask();
    do_reset();
    ready = 1'b1; en = 1'b1; mask = 6'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || svalid !== 1'b0) begin
        failures++;
        $display("FAIL empty_idle%0d busy=%b valid=%b required 0/0", i, busy, svalid);
      end
    end
    mask = 6'b001000;
    tick();
    checks++;
    if (sel !== 3'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL empty_then_sel sel=%0d busy=%b required 3/1", sel, busy);
    end
    tick();
    checks++;
    if (svalid !== 1'b1 || sch !== 3'd3 || sdata !== 3'd4) begin
      failures++;
      $display("FAIL empty_then_sample valid=%b ch=%0d data=%0d required 1/3/4", svalid, sch, sdata);
    end
    en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL empty_final_idle busy=%b required=0", busy); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; mask = 6'd0;
    test_reset();
    test_full_scan();
    test_masked_scan();
    test_backpressure();
    test_enable();
    test_empty_mask();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
